// File: rtl/pe_pkg.sv
// Shared types and helpers for the row-convolution processing element.
// Holds the sequencer state enum, default sizes and the saturating adder.
package pe_pkg;

  localparam int DATA_W_DEF       = 16;
  localparam int ACC_W_DEF        = 32;
  localparam int IFMAP_DEPTH_DEF  = 12;
  localparam int FILTER_DEPTH_DEF = 224;
  localparam int PSUM_DEPTH_DEF   = 24;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WB, OUT, FIN} state_t;

  // Operands arrive sign-extended from a w-bit accumulator (w <= 63),
  // so the 64-bit sum cannot itself overflow before the clamp.
  function automatic logic signed [63:0] sat_add(input  logic signed [63:0] a,
                                                 input  logic signed [63:0] b,
                                                 input  int                 w,
                                                 output logic               clamped);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum     = a + b;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    clamped = 1'b0;
    if (sum > hi) begin
      sum     = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sum     = lo;
      clamped = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pe_row_mac_if.sv
// Result stream of the processing element: valid/ready with index tag.
interface pe_row_mac_if #(
  parameter int ACC_W      = 32,
  parameter int PSUM_DEPTH = 24
);
  localparam int PA_W = $clog2(PSUM_DEPTH);

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [PA_W-1:0]         out_idx;

  modport master (output out_valid, output out_data, output out_idx, input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_idx, output out_ready);
endinterface

// File: rtl/pe_spad.sv
// Generic scratchpad: synchronous write, combinational read, no reset.
module pe_spad #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 12,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(DEPTH))) mem[waddr] <= wdata;
  end

  assign rdata = (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/pe_row_mac.sv
// Row-convolution PE: sequences S-tap MACs per output and streams results.
// Optional PE_ROW_MAC_SAT_EN: saturating accumulate plus sticky sat_flag.
module pe_row_mac
  import pe_pkg::*;
#(
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int ACC_W        = ACC_W_DEF,
  parameter  int IFMAP_DEPTH  = IFMAP_DEPTH_DEF,
  parameter  int FILTER_DEPTH = FILTER_DEPTH_DEF,
  parameter  int PSUM_DEPTH   = PSUM_DEPTH_DEF,
  localparam int IA_W         = $clog2(IFMAP_DEPTH),
  localparam int FA_W         = $clog2(FILTER_DEPTH),
  localparam int PA_W         = $clog2(PSUM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FA_W-1:0]   cfg_filt_len,
  input  logic [PA_W:0]     cfg_num_out,
  input  logic [1:0]        cfg_stride,
  input  logic              cfg_accum,
  input  logic              ifmap_wr_en,
  input  logic [IA_W-1:0]   ifmap_addr,
  input  logic [DATA_W-1:0] ifmap_wdata,
  input  logic              filter_wr_en,
  input  logic [FA_W-1:0]   filter_addr,
  input  logic [DATA_W-1:0] filter_wdata,
  input  logic              psum_wr_en,
  input  logic [PA_W-1:0]   psum_addr,
  input  logic [ACC_W-1:0]  psum_wdata,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
`ifdef PE_ROW_MAC_SAT_EN
  output logic              sat_flag,
`endif
  pe_row_mac_if.master      out_if
);

  localparam int XW = ((IA_W > FA_W) ? IA_W : FA_W) + 2;

  state_t state, state_nx;

  logic [FA_W-1:0]          filt_len_q, s_q;
  logic [PA_W:0]            num_out_q;
  logic [1:0]               stride_q;
  logic                     accum_q;
  logic [PA_W-1:0]          e_q;
  logic [XW-1:0]            ibase_q;
  logic signed [ACC_W-1:0]  acc_q, acc_nx;
  logic                     cfg_err_q;

  logic signed [DATA_W-1:0]   ifmap_rd, filt_rd;
  logic signed [ACC_W-1:0]    psum_rd, prod_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [XW-1:0]              iaddr;
  logic [31:0]                need;
  logic                       cfg_ok, accept, hs, last_e, idle;
  logic                       psum_we;
  logic [PA_W-1:0]            psum_waddr;
  logic [ACC_W-1:0]           psum_wd;

  assign idle = (state == IDLE);

  // A window needs (E-1)*stride + S ifmap entries; reject anything that overruns.
  always_comb begin
    need   = (32'(cfg_num_out) - 32'd1) * 32'(cfg_stride) + 32'(cfg_filt_len);
    cfg_ok = (cfg_filt_len != '0) && (cfg_num_out != '0) && (cfg_stride != 2'd0) &&
             (32'(cfg_num_out) <= 32'(PSUM_DEPTH)) && (need <= 32'(IFMAP_DEPTH));
  end

  assign accept = idle && start && cfg_ok;
  assign iaddr  = ibase_q + XW'(s_q);

  pe_spad #(.WIDTH(DATA_W), .DEPTH(IFMAP_DEPTH)) u_ifmap (
    .clk(clk), .we(ifmap_wr_en && idle), .waddr(ifmap_addr), .wdata(ifmap_wdata),
    .raddr(iaddr[IA_W-1:0]), .rdata(ifmap_rd));

  pe_spad #(.WIDTH(DATA_W), .DEPTH(FILTER_DEPTH)) u_filter (
    .clk(clk), .we(filter_wr_en && idle), .waddr(filter_addr), .wdata(filter_wdata),
    .raddr(s_q), .rdata(filt_rd));

  assign psum_we    = (psum_wr_en && idle) || (state == WB);
  assign psum_waddr = (state == WB) ? e_q : psum_addr;
  assign psum_wd    = (state == WB) ? acc_q : psum_wdata;

  pe_spad #(.WIDTH(ACC_W), .DEPTH(PSUM_DEPTH)) u_psum (
    .clk(clk), .we(psum_we), .waddr(psum_waddr), .wdata(psum_wd),
    .raddr(e_q), .rdata(psum_rd));

  assign prod     = ifmap_rd * filt_rd;
  assign prod_ext = ACC_W'(prod);

`ifdef PE_ROW_MAC_SAT_EN
  logic               clamp;
  logic signed [63:0] sat_sum;
  logic               sat_q;

  always_comb begin
    sat_sum = sat_add(64'(acc_q), 64'(prod_ext), ACC_W, clamp);
    acc_nx  = ACC_W'(sat_sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       sat_q <= 1'b0;
    else if (accept)                sat_q <= 1'b0;
    else if (state == MAC && clamp) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  assign acc_nx = acc_q + prod_ext;
`endif

  // Result is presented straight from WB so each output costs S+2 cycles.
  assign out_if.out_valid = (state == WB) || (state == OUT);
  assign out_if.out_data  = acc_q;
  assign out_if.out_idx   = e_q;
  assign hs     = out_if.out_valid && out_if.out_ready;
  assign last_e = ({1'b0, e_q} == (num_out_q - (PA_W+1)'(1)));
  assign busy    = (state == LOAD) || (state == MAC) || (state == WB) || (state == OUT);
  assign done    = (state == FIN);
  assign cfg_err = cfg_err_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = MAC;
      MAC:     if (s_q == (filt_len_q - FA_W'(1))) state_nx = WB;
      WB, OUT: begin
        if (hs) state_nx = last_e ? FIN : LOAD;
        else    state_nx = OUT;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      filt_len_q <= cfg_filt_len;
      num_out_q  <= cfg_num_out;
      stride_q   <= cfg_stride;
      accum_q    <= cfg_accum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cfg_err_q <= 1'b0;
      e_q       <= '0;
      s_q       <= '0;
      ibase_q   <= '0;
      acc_q     <= '0;
    end else begin
      state     <= state_nx;
      cfg_err_q <= idle && start && !cfg_ok;
      case (state)
        IDLE: if (accept) begin
          e_q     <= '0;
          ibase_q <= '0;
        end
        LOAD: begin
          acc_q <= accum_q ? psum_rd : '0;
          s_q   <= '0;
        end
        MAC: begin
          acc_q <= acc_nx;
          s_q   <= s_q + FA_W'(1);
        end
        WB, OUT: if (hs && !last_e) begin
          e_q     <= e_q + PA_W'(1);
          ibase_q <= ibase_q + XW'(stride_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_mac.sv
// Directed scoreboard bench for pe_row_mac (default widths/depths).
module tb_pe_row_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_filt_len = '0;
  logic [5:0]  cfg_num_out = '0;
  logic [1:0]  cfg_stride = '0;
  logic        cfg_accum = 1'b0;
  logic        ifmap_wr_en = 1'b0;
  logic [3:0]  ifmap_addr = '0;
  logic [15:0] ifmap_wdata = '0;
  logic        filter_wr_en = 1'b0;
  logic [7:0]  filter_addr = '0;
  logic [15:0] filter_wdata = '0;
  logic        psum_wr_en = 1'b0;
  logic [4:0]  psum_addr = '0;
  logic [31:0] psum_wdata = '0;
  logic        busy, done, cfg_err;
`ifdef PE_ROW_MAC_SAT_EN
  logic        sat_flag;
`endif

  pe_row_mac_if #(.ACC_W(32), .PSUM_DEPTH(24)) oif ();

  pe_row_mac dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_filt_len(cfg_filt_len), .cfg_num_out(cfg_num_out),
    .cfg_stride(cfg_stride), .cfg_accum(cfg_accum),
    .ifmap_wr_en(ifmap_wr_en), .ifmap_addr(ifmap_addr), .ifmap_wdata(ifmap_wdata),
    .filter_wr_en(filter_wr_en), .filter_addr(filter_addr), .filter_wdata(filter_wdata),
    .psum_wr_en(psum_wr_en), .psum_addr(psum_addr), .psum_wdata(psum_wdata),
    .busy(busy), .done(done), .cfg_err(cfg_err),
`ifdef PE_ROW_MAC_SAT_EN
    .sat_flag(sat_flag),
`endif
    .out_if(oif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Monitor: every accepted result is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst && oif.out_valid && oif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got idx=%0d data=%0d required no output",
                 oif.out_idx, oif.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_idx", longint'(oif.out_idx), longint'(e.idx));
        check("out_data", longint'(oif.out_data), longint'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_ifmap(input int a, input int v);
    ifmap_wr_en = 1'b1; ifmap_addr = 4'(a); ifmap_wdata = 16'(v);
    tick(1);
    ifmap_wr_en = 1'b0;
  endtask

  task automatic wr_filter(input int a, input int v);
    filter_wr_en = 1'b1; filter_addr = 8'(a); filter_wdata = 16'(v);
    tick(1);
    filter_wr_en = 1'b0;
  endtask

  task automatic wr_psum(input int a, input int v);
    psum_wr_en = 1'b1; psum_addr = 5'(a); psum_wdata = 32'(v);
    tick(1);
    psum_wr_en = 1'b0;
  endtask

  task automatic start_job(input int s, input int e, input int st, input logic acc);
    cfg_filt_len = 8'(s); cfg_num_out = 6'(e); cfg_stride = 2'(st); cfg_accum = acc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_exp(input int idx, input int data);
    exp_t e;
    e.idx = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for done; checks busy is already low in that cycle.
  task automatic wait_done(input string name, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen != 0) check({name, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges from the start edge until out_valid is observed.
  task automatic wait_valid(output int lat);
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (oif.out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    oif.out_ready = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_valid", oif.out_valid, 0);
    check("rst_out_data", oif.out_data, 0);
    check("rst_out_idx", oif.out_idx, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);

    // Single output: 1*4 + 2*5 + 3*6 = 32, valid five edges after start.
    wr_ifmap(0, 1); wr_ifmap(1, 2); wr_ifmap(2, 3);
    wr_filter(0, 4); wr_filter(1, 5); wr_filter(2, 6);
    push_exp(0, 32);
    start_job(3, 1, 1, 1'b0);
    check("single_busy", busy, 1);
    wait_valid(lat);
    check("single_latency", lat, 5);
    wait_done("single", 20);

    // Sliding window stride 2 over 0..11 with a box filter: 6e+3.
    for (int i = 0; i < 12; i++) wr_ifmap(i, i);
    for (int i = 0; i < 3; i++) wr_filter(i, 1);
    for (int e = 0; e < 4; e++) push_exp(e, 6 * e + 3);
    start_job(3, 4, 2, 1'b0);
    wait_done("window", 100);
    for (int e = 0; e < 4; e++) check("window_psum", dut.u_psum.mem[e], 6 * e + 3);

    // Accumulate with negative product: 100 + (-3 * 7) = 79, S = 1.
    wr_psum(0, 100);
    wr_ifmap(0, -3);
    wr_filter(0, 7);
    push_exp(0, 79);
    start_job(1, 1, 1, 1'b1);
    wait_done("accum", 20);

    // Backpressure: stride 1, outputs 0+1+2=3 and 1+2+3=6.
    wr_ifmap(0, 0);
    wr_filter(0, 1);
    push_exp(0, 3);
    push_exp(1, 6);
    oif.out_ready = 1'b0;
    start_job(3, 2, 1, 1'b0);
    wait_valid(lat);
    check("bp_latency", lat, 5);
    ifmap_wr_en = 1'b1; ifmap_addr = 4'd1; ifmap_wdata = 16'd999;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", oif.out_valid, 1);
      check("bp_data", oif.out_data, 3);
      check("bp_idx", oif.out_idx, 0);
      check("bp_busy", busy, 1);
      check("bp_no_done", done, 0);
    end
    @(posedge clk); #1;
    ifmap_wr_en = 1'b0;
    check("busy_write_ignored", dut.u_ifmap.mem[1], 1);
    oif.out_ready = 1'b1;
    wait_done("bp", 30);

    // Illegal window: (5-1)*3 + 4 = 16 > 12.
    start_job(4, 5, 3, 1'b0);
    check("illegal_cfg_err", cfg_err, 1);
    check("illegal_busy", busy, 0);
    tick(1);
    check("illegal_cfg_err_pulse", cfg_err, 0);
    check("illegal_still_idle", busy, 0);
    wr_ifmap(5, 77);
    check("write_after_reject", dut.u_ifmap.mem[5], 77);
    wr_ifmap(5, 5);

    // Reset during MAC aborts asynchronously; the next job completes normally.
    start_job(3, 1, 1, 1'b0);
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", oif.out_valid, 0);
    check("rst_mid_done", done, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("after_rst_done", done, 0);
    push_exp(0, 3);
    start_job(3, 1, 1, 1'b0);
    wait_done("after_rst", 20);

`ifdef PE_ROW_MAC_SAT_EN
    // Three products of 2^30 exceed the positive range and clamp.
    for (int i = 0; i < 3; i++) begin
      wr_ifmap(i, -32768);
      wr_filter(i, -32768);
    end
    push_exp(0, 32'h7fffffff);
    start_job(3, 1, 1, 1'b0);
    wait_done("sat", 20);
    check("sat_flag", sat_flag, 1);
`endif

    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/pe_row_mac.md
Name: pe_row_mac

Overview:
- Parametrised successor of the single-MAC processing element. Adds signed, configurable widths and depths, plus an internal sequencer.
- The sequencer runs a full 1-D row convolution (filter row × ifmap sliding window) autonomously after a start pulse. Partial sums accumulate into the local psum scratchpad.
- Results stream out over a valid/ready port.
- Sits in the PE array. The global buffer fills the scratchpads; the array controller issues start and drains outputs.

Parameters:
- DATA_W, 16, signed ifmap/filter element width.
- ACC_W, 32, signed accumulator/psum width (must be ≥ 2*DATA_W).
- IFMAP_DEPTH, 12, ifmap scratchpad entries.
- FILTER_DEPTH, 224, filter scratchpad entries.
- PSUM_DEPTH, 24, psum scratchpad entries.
- IA_W / FA_W / PA_W: derived $clog2 of each depth; these are localparams, not overridable.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- start in 1: one-cycle pulse; samples the cfg_* inputs.
- cfg_filt_len in FA_W: S, taps per output (1..FILTER_DEPTH).
- cfg_num_out in PA_W+1: E, outputs to compute (1..PSUM_DEPTH).
- cfg_stride in 2: stride, 1..3.
- cfg_accum in 1: 1 = seed each output from psum spad[e]; 0 = seed with 0.
- ifmap_wr_en / ifmap_addr / ifmap_wdata in 1 / IA_W / DATA_W: ifmap scratchpad write port.
- filter_wr_en / filter_addr / filter_wdata in 1 / FA_W / DATA_W: filter scratchpad write port.
- psum_wr_en / psum_addr / psum_wdata in 1 / PA_W / ACC_W: psum scratchpad write port.
- busy out 1: high from accepted start until done.
- done out 1: one-cycle pulse after the last output handshake.
- cfg_err out 1: one-cycle pulse when start is rejected.
- out_valid out 1: result valid.
- out_ready in 1: downstream accept.
- out_data out ACC_W: signed result.
- out_idx out PA_W: output index e.

Behaviour:

Reset:
- All outputs go to 0 and the FSM goes to IDLE.
- Scratchpad contents are not cleared.

Scratchpads:
- Synchronous write, combinational read.
- External writes are honoured only in IDLE; they are ignored while busy.

Start validation (evaluated in IDLE on start):
- Reject if S = 0, E = 0, stride = 0, or E > PSUM_DEPTH.
- Reject if (E-1)*stride + S > IFMAP_DEPTH.
- On reject: cfg_err pulses for 1 cycle and the FSM stays IDLE.
- start while busy is ignored.

FSM:
- IDLE → LOAD on a valid start. Latch the config; e = 0.
- LOAD (1 cycle): acc = cfg_accum ? psum[e] : 0; s = 0.
- MAC (S cycles): acc += sext(ifmap[e*stride+s] * filter[s]); s++. Leave after s = S-1.
- WB (1 cycle): psum[e] ← acc; out_data = acc; out_idx = e; out_valid = 1.
- OUT: hold out_valid, out_data and out_idx stable until out_ready.
  - On handshake: if e = E-1, go to FIN; else e++ and go to LOAD.
- FIN: done = 1 for 1 cycle, busy = 0, return to IDLE.

Timing:
- One output takes S+2 cycles plus stall cycles.
- If out_ready is held high, the first result is valid S+2 cycles after start.

Arithmetic:
- Signed DATA_W×DATA_W → 2*DATA_W product, sign-extended to ACC_W.
- Accumulation is modulo 2^ACC_W (wrap) unless the optional feature is enabled.

Boundary conditions:
- S = 1 gives a single MAC cycle.
- out_valid never drops without a handshake.
- rst asserted mid-operation aborts immediately: no done pulse, and the partially written psum spad is left as is.
- When the index reaches the last scratchpad entry there is no wrap; the start check guarantees it is never exceeded.

Optional Feature:
- Macro: PE_ROW_MAC_SAT_EN.
- Defined: each accumulate saturates to the ACC_W signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Output sat_flag (1 bit) is sticky per job, cleared on accepted start, and set if any clamp occurred.
- Undefined: wrap-around arithmetic and no sat_flag port.

Decomposition:
- Shared package pe_pkg holds:
  - the FSM state enum (IDLE, LOAD, MAC, WB, OUT, FIN);
  - default width/depth localparams;
  - a sat_add function used under the macro.
- One natural sub-module, pe_spad: a generic parametrised (WIDTH, DEPTH) scratchpad with sync write and async read. It is instantiated three times.

Test Plan:
- Single output: S=3, E=1, stride=1, accum=0, ifmap={1,2,3}, filter={4,5,6}. Expect out_data=32, out_idx=0, valid 5 cycles after start, then a done pulse.
- Sliding window: ifmap=0..11, filter={1,1,1}, S=3, E=4, stride=2, out_ready=1. Expect outputs {3,9,15,21} at idx 0..3 and psum spad updated with the same values.
- Accumulate and sign: psum[0]=100, accum=1, ifmap={-3}, filter={7}, S=1. Expect out_data=79.
- Backpressure: hold out_ready=0 for 10 cycles. out_data and out_idx stay stable, busy stays 1, and done comes only after release.
- Illegal config: S=4, E=5, stride=3 (needs 16 > 12). Expect a cfg_err pulse, busy stays 0; writes still accepted afterwards.
- Reset mid-MAC: assert rst during MAC. Expect busy=0 and out_valid=0 asynchronously. The next valid start completes normally. Under PE_ROW_MAC_SAT_EN, ifmap=filter=-32768 repeated S=3 saturates to 2^31-1 and sets sat_flag.
